// File: rtl/codec_ctrl_req_pkg.sv
// Shared types and constants for the codec control request front end.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package codec_ctrl_req_pkg;

    localparam int CLK_HZ_DEF      = 50_000_000;
    localparam int DEBOUNCE_MS_DEF = 20;

    // Cycles a key must hold a new level before the debouncer accepts it.
    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return ms * (clk_hz / 1000);
    endfunction

    localparam int DEBOUNCE_CNT = DEBOUNCE_MS_DEF * (CLK_HZ_DEF / 1000);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_GAP       = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_e;

    // Request classes, listed in issue priority order.
    typedef enum logic [1:0] {
        REQ_MIC  = 2'd0,
        REQ_VOL  = 2'd1,
        REQ_BCLK = 2'd2,
        REQ_NONE = 2'd3
    } req_cls_e;

    typedef struct packed {
        logic mic;
        logic vol;
        logic bclk;
    } pend_t;

endpackage

// File: rtl/codec_ctrl_req_if.sv
// Control bus between the request front end and the WM8960 init engine.
// Latency: n/a (wires only).
// Backpressure: i2c_idle low holds off new requests; Go strobes are not acknowledged.
interface codec_ctrl_req_if;
    logic       i2c_idle;
    logic       MICB_Power;
    logic       MICB_Go;
    logic [7:0] volume_8;
    logic       vol_Go;
    logic [3:0] BCLK_ctrl;
    logic       BCLK_Go;
    logic       busy;

    modport master (
        input  i2c_idle,
        output MICB_Power, MICB_Go, volume_8, vol_Go, BCLK_ctrl, BCLK_Go, busy
    );

    modport slave (
        output i2c_idle,
        input  MICB_Power, MICB_Go, volume_8, vol_Go, BCLK_ctrl, BCLK_Go, busy
    );
endinterface

// File: rtl/codec_ctrl_req_key_debounce.sv
// Key debouncer: 2-FF sync, stability counter, one-cycle pulse per accepted press.
// Latency: press pulse ~CNT+3 cycles after the raw key settles low.
// Backpressure: none; the pulse is fire-and-forget.
module codec_ctrl_req_key_debounce
    import codec_ctrl_req_pkg::*;
#(
    parameter int CNT = DEBOUNCE_CNT
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = (CNT > 1) ? $clog2(CNT + 1) : 1;

    logic          sync1_q;
    logic          sync2_q;
    logic          samp_q;
    logic          stable_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;
    logic          settled;
    logic          matured;

    // The synced level has not moved since last cycle and differs from the accepted level.
    assign settled = (sync2_q == samp_q) && (sync2_q != stable_q);
    assign matured = (cnt_q == CW'(CNT - 1));

    // Synchronise the raw key and keep one extra sample to detect changes; released = 1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            samp_q  <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            samp_q  <= sync2_q;
        end
    end

    // Count stable cycles of a new level; any change restarts the count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q <= '0;
        end else if (!settled || matured) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // Accept the new level once mature; only a 1->0 acceptance is a press.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            press_q <= settled && matured && !sync2_q;
            if (settled && matured) begin
                stable_q <= sync2_q;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/codec_ctrl_req.sv
// Panel-key front end for WM8960 config: settings regs, coalescing pendings, serialised Go strobes.
// Latency: press accepted in IDLE with i2c_idle high -> Go strobe 3 cycles later.
// Backpressure: one request in flight; waits GAP_CYCLES then for i2c_idle before the next.
module codec_ctrl_req
    import codec_ctrl_req_pkg::*;
#(
    parameter int         CLK_HZ      = CLK_HZ_DEF,
    parameter int         DEBOUNCE_MS = DEBOUNCE_MS_DEF,
    parameter logic [7:0] VOL_DEFAULT = 8'd200,
    parameter logic [7:0] VOL_STEP    = 8'd8,
    parameter logic [3:0] BCLK_MAX    = 4'd7,
    parameter int         GAP_CYCLES  = 64
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             key_vol_up_n,
    input  logic             key_vol_dn_n,
    input  logic             key_mic_n,
    input  logic             key_bclk_n,
    codec_ctrl_req_if.master ctl
);
    localparam int DB_CNT = debounce_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    logic press_up, press_dn, press_mic, press_bclk;
    logic vol_up_only, vol_dn_only;

    logic       mic_r;
    logic [7:0] vol_r;
    logic [3:0] bclk_r;
    logic [8:0] vol_sum;
    logic [7:0] vol_inc, vol_dec;

    pend_t    pend_q;
    state_e   state_q, state_d;
    req_cls_e issue_cls;
    logic [GW-1:0] gap_cnt_q;

    logic       micb_sh_q, micb_go_q;
    logic [7:0] vol_sh_q;
    logic       vol_go_q;
    logic [3:0] bclk_sh_q;
    logic       bclk_go_q;

    codec_ctrl_req_key_debounce #(.CNT(DB_CNT)) u_db_up   (.Clk, .Rst_n, .key_n(key_vol_up_n), .press(press_up));
    codec_ctrl_req_key_debounce #(.CNT(DB_CNT)) u_db_dn   (.Clk, .Rst_n, .key_n(key_vol_dn_n), .press(press_dn));
    codec_ctrl_req_key_debounce #(.CNT(DB_CNT)) u_db_mic  (.Clk, .Rst_n, .key_n(key_mic_n),    .press(press_mic));
    codec_ctrl_req_key_debounce #(.CNT(DB_CNT)) u_db_bclk (.Clk, .Rst_n, .key_n(key_bclk_n),   .press(press_bclk));

    // Up and down in the same cycle cancel out entirely.
    assign vol_up_only = press_up && !press_dn;
    assign vol_dn_only = press_dn && !press_up;

    // Saturating volume step: 9-bit sum clips at 255, subtraction clips at 0.
    always_comb begin
        vol_sum = {1'b0, vol_r} + {1'b0, VOL_STEP};
        vol_inc = vol_sum[8] ? 8'hFF : vol_sum[7:0];
        vol_dec = (vol_r < VOL_STEP) ? 8'h00 : (vol_r - VOL_STEP);
    end

    // Working settings follow presses immediately, whatever the FSM is doing.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mic_r  <= 1'b0;
            vol_r  <= VOL_DEFAULT;
            bclk_r <= 4'd0;
        end else begin
            if (vol_up_only) begin
                vol_r <= vol_inc;
            end else if (vol_dn_only) begin
                vol_r <= vol_dec;
            end
            if (press_mic) begin
                mic_r <= ~mic_r;
            end
            if (press_bclk) begin
                bclk_r <= (bclk_r == BCLK_MAX) ? 4'd0 : bclk_r + 4'd1;
            end
        end
    end

    // Pending flags: a press sets, issuing clears, and a same-cycle press wins.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q.mic  <= press_mic                      ? 1'b1 :
                           (issue_cls == REQ_MIC)          ? 1'b0 : pend_q.mic;
            pend_q.vol  <= (vol_up_only || vol_dn_only)   ? 1'b1 :
                           (issue_cls == REQ_VOL)          ? 1'b0 : pend_q.vol;
            pend_q.bclk <= press_bclk                     ? 1'b1 :
                           (issue_cls == REQ_BCLK)         ? 1'b0 : pend_q.bclk;
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and issue selection; mic has priority over vol over bclk.
    always_comb begin
        state_d   = state_q;
        issue_cls = REQ_NONE;
        case (state_q)
            ST_IDLE: begin
                if ((pend_q != '0) && ctl.i2c_idle) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (pend_q.mic) begin
                    issue_cls = REQ_MIC;
                end else if (pend_q.vol) begin
                    issue_cls = REQ_VOL;
                end else if (pend_q.bclk) begin
                    issue_cls = REQ_BCLK;
                end
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (ctl.i2c_idle) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gap counter gives the init engine time to drop i2c_idle before it is trusted.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            gap_cnt_q <= '0;
        end else if (state_q == ST_GAP) begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
        end else begin
            gap_cnt_q <= '0;
        end
    end

    // Shadow outputs load only on issue and stay put until the next issue of that class.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            micb_sh_q <= 1'b0;
            vol_sh_q  <= VOL_DEFAULT;
            bclk_sh_q <= 4'd0;
            micb_go_q <= 1'b0;
            vol_go_q  <= 1'b0;
            bclk_go_q <= 1'b0;
        end else begin
            micb_go_q <= 1'b0;
            vol_go_q  <= 1'b0;
            bclk_go_q <= 1'b0;
            case (issue_cls)
                REQ_MIC: begin
                    micb_sh_q <= mic_r;
                    micb_go_q <= 1'b1;
                end
                REQ_VOL: begin
                    vol_sh_q <= vol_r;
                    vol_go_q <= 1'b1;
                end
                REQ_BCLK: begin
                    bclk_sh_q <= bclk_r;
                    bclk_go_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ctl.MICB_Power = micb_sh_q;
    assign ctl.MICB_Go    = micb_go_q;
    assign ctl.volume_8   = vol_sh_q;
    assign ctl.vol_Go     = vol_go_q;
    assign ctl.BCLK_ctrl  = bclk_sh_q;
    assign ctl.BCLK_Go    = bclk_go_q;
    assign ctl.busy       = (state_q != ST_IDLE);

endmodule
